// File: rtl/dbg_pkg.sv
// Shared definitions for the debug trace controller.
//   - DumpState  : states of the snapshot/drain sequencer
//   - DEF_*      : default widths used as parameter defaults by the top
//   - log_window_t : logging window bounds {win_start, win_end}
package dbg_pkg;

    localparam int DEF_EVENT_NUM   = 16;
    localparam int DEF_CNT_WIDTH   = 32;
    localparam int DEF_CYCLE_WIDTH = 64;

    // Window bounds are stored at the widest supported cycle width. A narrower
    // cycle counter is zero-extended before comparing, so CYCLE_WIDTH must not
    // exceed WIN_WIDTH.
    localparam int WIN_WIDTH = 64;

    typedef enum logic [1:0] {
        DUMP_IDLE,
        DUMP_SNAP,
        DUMP_DRAIN
    } DumpState;

    typedef struct packed {
        logic [WIN_WIDTH-1:0] win_start;
        logic [WIN_WIDTH-1:0] win_end;
    } log_window_t;

endpackage

// File: rtl/perf_counter_cell.sv
// One saturating performance event counter.
//   clk      in   core clock
//   rst      in   asynchronous reset, active-high
//   inc      in   increment strobe for this cycle
//   clr      in   clear the counter at this clock edge
//   next_val out  counter value including this cycle's increment (saturated);
//                 this is the value captured into the snapshot when clr is high
module perf_counter_cell #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] next_val
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // The increment of the clearing cycle goes into next_val (the snapshot)
    // and not into the cleared counter, so no event is lost or counted twice.
    always_comb begin
        next_val = cnt_q;
        if (inc && !(&cnt_q)) begin
            next_val = cnt_q + CNT_WIDTH'(1);
        end
        cnt_d = clr ? '0 : next_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_trace_ctrl.sv
// Central debug time base, log-enable gate and perf event counter bank.
//   clk, rst     core clock, asynchronous active-high reset
//   cfg_valid    load cfg_start/cfg_end as the new logging window
//   cfg_start    first cycle with logging enabled
//   cfg_end      first cycle with logging disabled again
//   event_i      per-counter increment strobes
//   dump_req     snapshot, clear and drain the counter bank (ignored while busy)
//   dump_valid / dump_ready / dump_idx / dump_data / dump_last
//                serial drain stream of the snapshot, one counter per beat
//   busy         sequencer not idle
//   cycle_cnt    free-running cycle count
//   log_valid    registered "cycle_cnt inside window" flag
module debug_trace_ctrl
    import dbg_pkg::*;
#(
    parameter int EVENT_NUM   = DEF_EVENT_NUM,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int CYCLE_WIDTH = DEF_CYCLE_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    input  logic [CYCLE_WIDTH-1:0]        cfg_start,
    input  logic [CYCLE_WIDTH-1:0]        cfg_end,
    input  logic [EVENT_NUM-1:0]          event_i,
    input  logic                          dump_req,
    output logic                          dump_valid,
    input  logic                          dump_ready,
    output logic [$clog2(EVENT_NUM)-1:0]  dump_idx,
    output logic [CNT_WIDTH-1:0]          dump_data,
    output logic                          dump_last,
    output logic                          busy,
    output logic [CYCLE_WIDTH-1:0]        cycle_cnt,
    output logic                          log_valid
);

    localparam int IDX_W = $clog2(EVENT_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EVENT_NUM - 1);

    logic [CYCLE_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic                   log_valid_q, log_valid_d;
    log_window_t            win_q, win_d;

    DumpState               state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   shadow_q [EVENT_NUM];
    logic [CNT_WIDTH-1:0]   shadow_d [EVENT_NUM];
    logic [CNT_WIDTH-1:0]   snap_val [EVENT_NUM];
    logic                   snap_clr;

    assign snap_clr = (state_q == DUMP_SNAP);

    for (genvar g = 0; g < EVENT_NUM; g++) begin : g_cell
        perf_counter_cell #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .inc      (event_i[g]),
            .clr      (snap_clr),
            .next_val (snap_val[g])
        );
    end

    // The compare uses the window held before this edge, so a window loaded
    // by cfg_valid first takes effect on the following cycle.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + CYCLE_WIDTH'(1);
        log_valid_d = (WIN_WIDTH'(cycle_cnt_q) >= win_q.win_start) &&
                      (WIN_WIDTH'(cycle_cnt_q) <  win_q.win_end);
        win_d = win_q;
        if (cfg_valid) begin
            win_d.win_start = WIN_WIDTH'(cfg_start);
            win_d.win_end   = WIN_WIDTH'(cfg_end);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q       <= '0;
            log_valid_q       <= 1'b0;
            win_q.win_start   <= '0;
            win_q.win_end     <= WIN_WIDTH'({CYCLE_WIDTH{1'b1}});
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            log_valid_q <= log_valid_d;
            win_q       <= win_d;
        end
    end

    // A request arriving outside IDLE is dropped rather than queued.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_req) begin
                    state_d = DUMP_SNAP;
                end
            end
            DUMP_SNAP: begin
                for (int i = 0; i < EVENT_NUM; i++) begin
                    shadow_d[i] = snap_val[i];
                end
                idx_d   = '0;
                state_d = DUMP_DRAIN;
            end
            DUMP_DRAIN: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DUMP_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = DUMP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
            for (int i = 0; i < EVENT_NUM; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

    // Stream outputs decode the state register directly so an asynchronous
    // reset drops dump_valid without waiting for a clock edge.
    always_comb begin
        dump_valid = (state_q == DUMP_DRAIN);
        dump_idx   = idx_q;
        dump_data  = dump_valid ? shadow_q[idx_q] : '0;
        dump_last  = dump_valid && (idx_q == LAST_IDX);
        busy       = (state_q != DUMP_IDLE);
    end

    assign cycle_cnt = cycle_cnt_q;
    assign log_valid = log_valid_q;

endmodule

// File: tb/tb_debug_trace_ctrl.sv
// Directed self-checking bench for debug_trace_ctrl. A 4-bit counter width is
// used so saturation can be reached in a handful of cycles. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_debug_trace_ctrl;

    localparam int EN = 16;
    localparam int CW = 4;
    localparam int YW = 64;

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic [YW-1:0] cfg_start;
    logic [YW-1:0] cfg_end;
    logic [EN-1:0] event_i;
    logic          dump_req;
    logic          dump_valid;
    logic          dump_ready;
    logic [3:0]    dump_idx;
    logic [CW-1:0] dump_data;
    logic          dump_last;
    logic          busy;
    logic [YW-1:0] cycle_cnt;
    logic          log_valid;

    int checks;
    int failures;

    debug_trace_ctrl #(
        .EVENT_NUM   (EN),
        .CNT_WIDTH   (CW),
        .CYCLE_WIDTH (YW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_start  (cfg_start),
        .cfg_end    (cfg_end),
        .event_i    (event_i),
        .dump_req   (dump_req),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .busy       (busy),
        .cycle_cnt  (cycle_cnt),
        .log_valid  (log_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    // Reset pulse that leaves the bench on a falling edge with cycle_cnt=0.
    task automatic do_reset();
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_start  = '0;
        cfg_end    = '0;
        event_i    = '0;
        dump_req   = 1'b0;
        dump_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_start  = '0;
        cfg_end    = '0;
        event_i    = '0;
        dump_req   = 1'b0;
        dump_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cycle_cnt !== 64'd0 || log_valid !== 1'b0 || busy !== 1'b0 ||
            dump_valid !== 1'b0 || dump_last !== 1'b0 ||
            dump_idx !== 4'd0 || dump_data !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_state cyc=%0d lv=%b busy=%b v=%b last=%b idx=%0d data=%0d exp all zero",
                     cycle_cnt, log_valid, busy, dump_valid, dump_last, dump_idx, dump_data);
        end
        rst = 1'b0;
        checks++;
        if (log_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_lv got=%b exp=0", log_valid);
        end
        @(negedge clk);
        checks++;
        if (cycle_cnt !== 64'd1 || log_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_cycle cyc=%0d lv=%b exp cyc=1 lv=1", cycle_cnt, log_valid);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (cycle_cnt !== 64'd10 || log_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ten_cycles cyc=%0d lv=%b exp cyc=10 lv=1", cycle_cnt, log_valid);
        end
    endtask

    task automatic test_window();
        logic exp_lv;
        do_reset();
        cfg_valid = 1'b1;
        cfg_start = 64'd20;
        cfg_end   = 64'd25;
        @(negedge clk);
        cfg_valid = 1'b0;
        // Cycle 1 still reflects the default window; afterwards 21..25 only.
        for (int c = 1; c <= 30; c++) begin
            exp_lv = (c == 1) || (c >= 21 && c <= 25);
            checks++;
            if (cycle_cnt !== 64'(c) || log_valid !== exp_lv) begin
                failures++;
                $display("[TB] FAIL window_20_25 cyc=%0d lv=%b exp cyc=%0d lv=%b",
                         cycle_cnt, log_valid, c, exp_lv);
            end
            @(negedge clk);
        end
        cfg_valid = 1'b1;
        cfg_start = 64'd30;
        cfg_end   = 64'd30;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (log_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL window_empty cyc=%0d lv=%b exp=0", cycle_cnt, log_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_event_dump();
        logic [CW-1:0] exp_d;
        do_reset();
        event_i = 16'h0008;
        repeat (7) @(negedge clk);
        event_i    = '0;
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || dump_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL snap_state busy=%b v=%b exp busy=1 v=0", busy, dump_valid);
        end
        @(negedge clk);
        for (int k = 0; k < EN; k++) begin
            exp_d = (k == 3) ? 4'd7 : 4'd0;
            checks++;
            if (dump_valid !== 1'b1 || dump_idx !== 4'(k) || dump_data !== exp_d ||
                dump_last !== (k == EN - 1)) begin
                failures++;
                $display("[TB] FAIL beat_event3 k=%0d got v=%b idx=%0d data=%0d last=%b exp v=1 idx=%0d data=%0d last=%b",
                         k, dump_valid, dump_idx, dump_data, dump_last, k, exp_d, (k == EN - 1));
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || dump_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_done busy=%b v=%b exp 0 0", busy, dump_valid);
        end
    endtask

    task automatic test_snap_boundary();
        logic [CW-1:0] exp_d;
        do_reset();
        event_i = 16'h0001;
        repeat (5) @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        @(negedge clk);
        // Counter was 6 entering SNAP; the SNAP-cycle event lands in the snapshot.
        checks++;
        if (dump_valid !== 1'b1 || dump_idx !== 4'd0 || dump_data !== 4'd7) begin
            failures++;
            $display("[TB] FAIL snap_idx0 v=%b idx=%0d data=%0d exp v=1 idx=0 data=7",
                     dump_valid, dump_idx, dump_data);
        end
        @(negedge clk);
        checks++;
        if (dump_valid !== 1'b1 || dump_idx !== 4'd0 || dump_data !== 4'd7) begin
            failures++;
            $display("[TB] FAIL hold_idx0 v=%b idx=%0d data=%0d exp v=1 idx=0 data=7",
                     dump_valid, dump_idx, dump_data);
        end
        dump_ready = 1'b1;
        @(negedge clk);
        dump_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dump_valid !== 1'b1 || dump_idx !== 4'd1 || dump_data !== 4'd0) begin
            failures++;
            $display("[TB] FAIL hold_idx1 v=%b idx=%0d data=%0d exp v=1 idx=1 data=0",
                     dump_valid, dump_idx, dump_data);
        end
        dump_ready = 1'b1;
        @(negedge clk);
        event_i = '0;
        for (int k = 2; k < EN; k++) begin
            checks++;
            if (dump_idx !== 4'(k) || dump_data !== 4'd0 || dump_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL drain_rest k=%0d idx=%0d data=%0d v=%b exp idx=%0d data=0 v=1",
                         k, dump_idx, dump_data, dump_valid, k);
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_done2 busy=%b exp=0", busy);
        end
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        @(negedge clk);
        for (int k = 0; k < EN; k++) begin
            exp_d = (k == 0) ? 4'd4 : 4'd0;
            checks++;
            if (dump_idx !== 4'(k) || dump_data !== exp_d || dump_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL second_dump k=%0d idx=%0d data=%0d v=%b exp idx=%0d data=%0d v=1",
                         k, dump_idx, dump_data, dump_valid, k, exp_d);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturate_and_ignore();
        logic [CW-1:0] exp_d;
        do_reset();
        event_i = 16'h0002;
        repeat (17) @(negedge clk);
        event_i    = '0;
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        @(negedge clk);
        for (int k = 0; k < EN; k++) begin
            dump_req = (k == 4) || (k == EN - 1);
            exp_d = (k == 1) ? 4'd15 : 4'd0;
            checks++;
            if (dump_valid !== 1'b1 || dump_idx !== 4'(k) || dump_data !== exp_d ||
                dump_last !== (k == EN - 1)) begin
                failures++;
                $display("[TB] FAIL sat_beat k=%0d v=%b idx=%0d data=%0d last=%b exp v=1 idx=%0d data=%0d last=%b",
                         k, dump_valid, dump_idx, dump_data, dump_last, k, exp_d, (k == EN - 1));
            end
            @(negedge clk);
        end
        dump_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (busy !== 1'b0 || dump_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL req_ignored c=%0d busy=%b v=%b exp 0 0", c, busy, dump_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (dump_idx !== 4'd5 || dump_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset idx=%0d v=%b exp idx=5 v=1", dump_idx, dump_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dump_valid !== 1'b0 || busy !== 1'b0 || cycle_cnt !== 64'd0 || dump_idx !== 4'd0) begin
            failures++;
            $display("[TB] FAIL async_reset v=%b busy=%b cyc=%0d idx=%0d exp 0 0 0 0",
                     dump_valid, busy, cycle_cnt, dump_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dump_valid !== 1'b0 || cycle_cnt !== 64'd1) begin
            failures++;
            $display("[TB] FAIL after_reset busy=%b v=%b cyc=%0d exp 0 0 1", busy, dump_valid, cycle_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_window();
        test_single_event_dump();
        test_snap_boundary();
        test_saturate_and_ignore();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
